// File: rtl/mcy_mutant_sweep_ctrl_if.sv
// Result channel of the mutant sweep controller: one record per swept mutant,
// handed over with a valid/ready handshake.
interface mcy_mutant_sweep_ctrl_if #(
   parameter int unsigned MUTSEL_W = 8,
   parameter int unsigned VEC_W    = 10
);
   logic                res_valid_o;
   logic                res_ready_i;
   logic [MUTSEL_W-1:0] res_mutidx_o;
   logic                res_killed_o;
   logic [VEC_W-1:0]    res_kill_vec_o;

   // Controller side: produces results.
   modport master (
      output res_valid_o,
      output res_mutidx_o,
      output res_killed_o,
      output res_kill_vec_o,
      input  res_ready_i
   );

   // Consumer side: accepts results.
   modport slave (
      input  res_valid_o,
      input  res_mutidx_o,
      input  res_killed_o,
      input  res_kill_vec_o,
      output res_ready_i
   );
endinterface

// File: rtl/mcy_mutant_sweep_ctrl.sv
// Mutation-coverage sweep controller for the mutated decoder harness.
// Walks mutant indices first..last, drives a reseeded Galois LFSR instruction
// stream into golden and mutated decoders, watches the external mismatch flag
// and reports killed/survived for every mutant over a valid/ready channel.
module mcy_mutant_sweep_ctrl #(
   parameter int unsigned MUTSEL_W  = 8,
   parameter int unsigned VEC_W     = 10,
   parameter int unsigned NUM_VECS  = 256,
   parameter logic [31:0] LFSR_SEED = 32'h1F2E_3D4C
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [MUTSEL_W-1:0] mut_first_i,
   input  logic [MUTSEL_W-1:0] mut_last_i,
   output logic [MUTSEL_W-1:0] mutsel_o,
   output logic [31:0]         instr_rdata_o,
   output logic                illegal_c_insn_o,
   input  logic                mismatch_i,
   mcy_mutant_sweep_ctrl_if.master res,
   output logic [MUTSEL_W:0]   killed_cnt_o,
   output logic [MUTSEL_W:0]   survived_cnt_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                range_err_o
);
   localparam logic [31:0]         TAPS     = 32'h8020_0003;
   // One extra bit so the counter can hold NUM_VECS == 2**VEC_W.
   localparam int unsigned         CNT_W    = VEC_W + 1;
   localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]    LAST_VEC = CNT_W'(NUM_VECS - 1);
   localparam logic [MUTSEL_W-1:0] MUT_ONE  = MUTSEL_W'(1);
   localparam logic [MUTSEL_W:0]   RES_ONE  = (MUTSEL_W+1)'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_DRIVE, S_DRAIN, S_REPORT, S_DONE
   } state_t;

   state_t              state_reg;
   logic [MUTSEL_W-1:0] cur_reg;
   logic [MUTSEL_W-1:0] last_reg;
   logic [MUTSEL_W-1:0] mutsel_reg;
   logic [31:0]         lfsr_reg;
   logic [31:0]         lfsr_next;
   logic [31:0]         instr_reg;
   logic [CNT_W-1:0]    vec_cnt_reg;
   logic                killed_reg;
   logic [VEC_W-1:0]    kill_vec_reg;
   logic                res_valid_reg;
   logic [MUTSEL_W:0]   killed_cnt_reg;
   logic [MUTSEL_W:0]   survived_cnt_reg;
   logic                busy_reg;
   logic                done_reg;
   logic                range_err_reg;
   logic [MUTSEL_W-1:0] eff_first;
   logic [VEC_W-1:0]    prev_vec;

   // Right-shifting Galois LFSR step: feedback bit 0 is XORed into tapped positions.
   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_lfsr
         if (gi == 31) begin : g_top
            assign lfsr_next[gi] = TAPS[gi] & lfsr_reg[0];
         end else begin : g_mid
            assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (TAPS[gi] & lfsr_reg[0]);
         end
      end
   endgenerate

   // Index 0 is the unmutated design and is never swept; a mismatch refers to the vector before vec_cnt.
   always_comb begin
      eff_first = (mut_first_i == '0) ? MUT_ONE : mut_first_i;
      prev_vec  = VEC_W'(vec_cnt_reg - CNT_ONE);
   end

   // Sweep sequencer with all outputs registered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg        <= S_IDLE;
         cur_reg          <= '0;
         last_reg         <= '0;
         mutsel_reg       <= '0;
         lfsr_reg         <= LFSR_SEED;
         instr_reg        <= '0;
         vec_cnt_reg      <= '0;
         killed_reg       <= 1'b0;
         kill_vec_reg     <= '0;
         res_valid_reg    <= 1'b0;
         killed_cnt_reg   <= '0;
         survived_cnt_reg <= '0;
         busy_reg         <= 1'b0;
         done_reg         <= 1'b0;
         range_err_reg    <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  killed_cnt_reg   <= '0;
                  survived_cnt_reg <= '0;
                  cur_reg          <= eff_first;
                  last_reg         <= mut_last_i;
                  if (mut_last_i < eff_first) begin
                     // Empty range: finish immediately without any result.
                     range_err_reg <= 1'b1;
                     done_reg      <= 1'b1;
                     busy_reg      <= 1'b0;
                     state_reg     <= S_DONE;
                  end else begin
                     range_err_reg <= 1'b0;
                     done_reg      <= 1'b0;
                     busy_reg      <= 1'b1;
                     state_reg     <= S_SETUP;
                  end
               end
            end
            S_SETUP: begin
               mutsel_reg   <= cur_reg;
               lfsr_reg     <= LFSR_SEED;
               vec_cnt_reg  <= '0;
               killed_reg   <= 1'b0;
               kill_vec_reg <= '0;
               state_reg    <= S_DRIVE;
            end
            S_DRIVE: begin
               if (vec_cnt_reg != '0 && mismatch_i) begin
                  // Early kill: freeze the stream on the offending vector.
                  killed_reg    <= 1'b1;
                  kill_vec_reg  <= prev_vec;
                  res_valid_reg <= 1'b1;
                  state_reg     <= S_REPORT;
               end else begin
                  instr_reg   <= {lfsr_reg[31:2], 2'b11};
                  lfsr_reg    <= lfsr_next;
                  vec_cnt_reg <= vec_cnt_reg + CNT_ONE;
                  if (vec_cnt_reg == LAST_VEC) begin
                     state_reg <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               // Last chance to see a mismatch on the final vector.
               if (mismatch_i) begin
                  killed_reg   <= 1'b1;
                  kill_vec_reg <= prev_vec;
               end
               res_valid_reg <= 1'b1;
               state_reg     <= S_REPORT;
            end
            S_REPORT: begin
               if (res.res_ready_i) begin
                  res_valid_reg <= 1'b0;
                  if (killed_reg) begin
                     killed_cnt_reg <= killed_cnt_reg + RES_ONE;
                  end else begin
                     survived_cnt_reg <= survived_cnt_reg + RES_ONE;
                  end
                  if (cur_reg == last_reg) begin
                     // Comparing before incrementing keeps last == max index from wrapping.
                     mutsel_reg <= '0;
                     busy_reg   <= 1'b0;
                     done_reg   <= 1'b1;
                     state_reg  <= S_DONE;
                  end else begin
                     cur_reg   <= cur_reg + MUT_ONE;
                     state_reg <= S_SETUP;
                  end
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign mutsel_o           = mutsel_reg;
   assign instr_rdata_o      = instr_reg;
   assign illegal_c_insn_o   = 1'b0;
   assign res.res_valid_o    = res_valid_reg;
   assign res.res_mutidx_o   = cur_reg;
   assign res.res_killed_o   = killed_reg;
   assign res.res_kill_vec_o = kill_vec_reg;
   assign killed_cnt_o       = killed_cnt_reg;
   assign survived_cnt_o     = survived_cnt_reg;
   assign busy_o             = busy_reg;
   assign done_o             = done_reg;
   assign range_err_o        = range_err_reg;
endmodule

// File: tb/tb_mcy_mutant_sweep_ctrl.sv
// Bench for the mutant sweep controller: a transaction-level model (expected
// result queue, software LFSR vector table, kill plan per mutant) checked every
// cycle by one monitor, plus directed sweeps with literal expectations.
module tb_mcy_mutant_sweep_ctrl;
   localparam int          NV   = 256;
   localparam logic [31:0] SEED = 32'h1F2E_3D4C;
   localparam logic [31:0] TAPS = 32'h8020_0003;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [7:0]  mut_first_i;
   logic [7:0]  mut_last_i;
   logic [7:0]  mutsel_o;
   logic [31:0] instr_rdata_o;
   logic        illegal_c_insn_o;
   logic        mismatch_i;
   logic [8:0]  killed_cnt_o;
   logic [8:0]  survived_cnt_o;
   logic        busy_o;
   logic        done_o;
   logic        range_err_o;

   mcy_mutant_sweep_ctrl_if #(.MUTSEL_W(8), .VEC_W(10)) res_if ();

   mcy_mutant_sweep_ctrl #(
      .MUTSEL_W(8), .VEC_W(10), .NUM_VECS(NV), .LFSR_SEED(SEED)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
      .mut_first_i(mut_first_i), .mut_last_i(mut_last_i),
      .mutsel_o(mutsel_o), .instr_rdata_o(instr_rdata_o),
      .illegal_c_insn_o(illegal_c_insn_o), .mismatch_i(mismatch_i),
      .res(res_if),
      .killed_cnt_o(killed_cnt_o), .survived_cnt_o(survived_cnt_o),
      .busy_o(busy_o), .done_o(done_o), .range_err_o(range_err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      bit killed;
      int kill_vec;
   } exp_t;

   int          tests_run = 0;
   int          fails = 0;
   logic [31:0] vec_tab [0:NV-1];
   int          kill_at [0:255];
   exp_t        exp_q [$];
   int          m_killed = 0;
   int          m_surv = 0;
   bit          clr_pending = 0;
   bit          lat_chk = 0;
   int          mm_k;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Stand-in for the golden/mutant comparator: the planned mutant diverges on exactly one vector.
   always_comb begin
      mismatch_i = 1'b0;
      mm_k = kill_at[mutsel_o];
      if (mutsel_o != 8'd0 && mm_k >= 0 && mm_k < NV)
         mismatch_i = (instr_rdata_o == vec_tab[mm_k]);
   end

   // Per-cycle compare process against the model.
   initial begin : monitor
      logic [7:0] prev_mutsel;
      int         age;
      bit         seen_res;
      bit         prev_valid;
      bit         prev_ready;
      exp_t       e;
      prev_mutsel = 8'd0; age = 0; seen_res = 0; prev_valid = 0; prev_ready = 0;
      forever begin
         @(negedge clk); #1;
         if (rst_i) begin
            m_killed = 0; m_surv = 0; clr_pending = 0;
            prev_mutsel = 8'd0; age = 0; seen_res = 0; prev_valid = 0; prev_ready = 0;
         end else begin
            check("illegal_c_insn", illegal_c_insn_o, 0);
            check("busy_and_done", busy_o & done_o, 0);
            check("killed_cnt", killed_cnt_o, m_killed);
            check("survived_cnt", survived_cnt_o, m_surv);
            if (clr_pending) begin
               m_killed = 0; m_surv = 0; clr_pending = 0;
            end
            age++;
            if (mutsel_o != prev_mutsel) begin
               if (mutsel_o == 8'd0) begin
                  check("results_left_at_done", exp_q.size(), 0);
               end else begin
                  if (exp_q.size() == 0) check("unexpected_mutant", mutsel_o, 0);
                  else check("mutsel_order", mutsel_o, exp_q[0].idx);
                  if (lat_chk && prev_mutsel != 8'd0) check("mutant_latency", age, 259);
               end
               age = 0; seen_res = 0; prev_mutsel = mutsel_o;
            end
            if (mutsel_o != 8'd0 && res_if.res_valid_o) seen_res = 1;
            if (mutsel_o != 8'd0 && age >= 1 && !seen_res) begin
               if (age <= NV) check("instr_stream", instr_rdata_o, vec_tab[age-1]);
               check("instr_low_bits", instr_rdata_o[1:0], 2'b11);
            end
            if (res_if.res_valid_o) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_result", exp_q.size(), 1);
               end else begin
                  e = exp_q[0];
                  check("res_mutidx", res_if.res_mutidx_o, e.idx);
                  check("res_killed", res_if.res_killed_o, e.killed);
                  check("res_kill_vec", res_if.res_kill_vec_o, e.kill_vec);
                  check("mutsel_in_report", mutsel_o, e.idx);
                  check("instr_held", instr_rdata_o, vec_tab[e.killed ? e.kill_vec : NV-1]);
                  if (res_if.res_ready_i) begin
                     $display("[TB] result mut=%0d killed=%0d kill_vec=%0d",
                              res_if.res_mutidx_o, res_if.res_killed_o, res_if.res_kill_vec_o);
                     if (e.killed) m_killed++;
                     else m_surv++;
                     void'(exp_q.pop_front());
                  end
               end
            end else if (prev_valid && !prev_ready) begin
               check("res_valid_dropped_without_accept", res_if.res_valid_o, 1);
            end
            prev_valid = res_if.res_valid_o;
            prev_ready = res_if.res_ready_i;
         end
      end
   end

   task automatic sweep(input int f, input int l);
      int   ef;
      exp_t e;
      ef = (f == 0) ? 1 : f;
      @(negedge clk);
      mut_first_i = 8'(f);
      mut_last_i  = 8'(l);
      start_i     = 1'b1;
      clr_pending = 1;
      for (int i = ef; i <= l; i++) begin
         e.idx      = i;
         e.killed   = (kill_at[i] >= 0);
         e.kill_vec = (kill_at[i] >= 0) ? kill_at[i] : 0;
         exp_q.push_back(e);
      end
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      for (int i = 0; i < budget && !done_o; i++) @(negedge clk);
      check(name, done_o, 1);
   endtask

   task automatic wait_valid(input int budget, input string name);
      for (int i = 0; i < budget && !res_if.res_valid_o; i++) @(negedge clk);
      check(name, res_if.res_valid_o, 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mutsel"}, mutsel_o, 0);
      check({tag, "_instr"}, instr_rdata_o, 0);
      check({tag, "_res_valid"}, res_if.res_valid_o, 0);
      check({tag, "_res_mutidx"}, res_if.res_mutidx_o, 0);
      check({tag, "_res_killed"}, res_if.res_killed_o, 0);
      check({tag, "_res_kill_vec"}, res_if.res_kill_vec_o, 0);
      check({tag, "_killed_cnt"}, killed_cnt_o, 0);
      check({tag, "_survived_cnt"}, survived_cnt_o, 0);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_done"}, done_o, 0);
      check({tag, "_range_err"}, range_err_o, 0);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got no completion, expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [31:0] x;
      rst_i = 1'b1; start_i = 1'b0; mut_first_i = 8'd0; mut_last_i = 8'd0;
      res_if.res_ready_i = 1'b1;
      for (int i = 0; i < 256; i++) kill_at[i] = -1;
      x = SEED;
      for (int i = 0; i < NV; i++) begin
         vec_tab[i] = {x[31:2], 2'b11};
         x = x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
      end
      // Hand-computed first vectors pin the software LFSR (v3 exercises the taps).
      check("model_v0", vec_tab[0], 32'h1F2E_3D4F);
      check("model_v1", vec_tab[1], 32'h0F97_1EA7);
      check("model_v2", vec_tab[2], 32'h07CB_8F53);
      check("model_v3", vec_tab[3], 32'h83C5_C7AB);

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_i = 1'b0;

      // 1: plain survivors 3..5, ready tied high, 259 cycles per mutant.
      lat_chk = 1;
      sweep(3, 5);
      check("t1_busy_after_start", busy_o, 1);
      wait_done(2000, "t1_done");
      lat_chk = 0;
      check("t1_survived", survived_cnt_o, 3);
      check("t1_killed", killed_cnt_o, 0);
      check("t1_busy", busy_o, 0);
      check("t1_mutsel_idle", mutsel_o, 0);

      // 2: single mutant killed on vector 10.
      kill_at[7] = 10;
      sweep(7, 7);
      wait_done(1000, "t2_done");
      check("t2_killed", killed_cnt_o, 1);
      check("t2_survived", survived_cnt_o, 0);
      check("t2_instr_frozen", instr_rdata_o, vec_tab[10]);

      // 3a: first=0 is raised to 1.
      sweep(0, 2);
      wait_done(2000, "t3a_done");
      check("t3a_survived", survived_cnt_o, 2);
      check("t3a_killed", killed_cnt_o, 0);
      check("t3a_range_err", range_err_o, 0);

      // 3b: empty range.
      sweep(9, 4);
      check("t3b_range_err", range_err_o, 1);
      check("t3b_done", done_o, 1);
      check("t3b_busy", busy_o, 0);
      check("t3b_survived", survived_cnt_o, 0);
      repeat (10) @(negedge clk);
      check("t3b_no_result", res_if.res_valid_o, 0);
      check("t3b_mutsel", mutsel_o, 0);
      check("t3b_range_err_held", range_err_o, 1);

      // 4: stalled results; kill on the final vector and on vector 0.
      kill_at[10] = 255;
      kill_at[11] = 0;
      res_if.res_ready_i = 1'b0;
      sweep(10, 11);
      for (int m = 10; m <= 11; m++) begin
         wait_valid(1000, "t4_valid");
         repeat (20) @(negedge clk);
         check("t4_valid_held", res_if.res_valid_o, 1);
         check("t4_mutsel_held", mutsel_o, m);
         res_if.res_ready_i = 1'b1;
         @(negedge clk);
         res_if.res_ready_i = 1'b0;
      end
      res_if.res_ready_i = 1'b1;
      wait_done(100, "t4_done");
      check("t4_killed", killed_cnt_o, 2);
      check("t4_survived", survived_cnt_o, 0);

      // 5: reset in the middle of mutant 4, then a full replay.
      sweep(2, 6);
      for (int i = 0; i < 2000 && mutsel_o != 8'd4; i++) @(negedge clk);
      check("t5_reached_mut4", mutsel_o, 4);
      repeat (50) @(negedge clk);
      check("t5_busy_mid", busy_o, 1);
      rst_i = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check_all_zero("t5_reset");
      rst_i = 1'b0;
      sweep(2, 6);
      wait_done(3000, "t5_done");
      check("t5_survived", survived_cnt_o, 5);
      check("t5_killed", killed_cnt_o, 0);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
